// File: rtl/program_loader.sv
`timescale 1ns/1ps
// program_loader
//   Boot-time loader for the single-cycle CPU core. Receives a byte stream
//   (header N, then 4*N big-endian data bytes, optionally a checksum byte),
//   writes the assembled words into instruction memory from address 0 upward,
//   then releases the CPU reset. A level 'reload' puts the CPU back into reset
//   and restarts loading; instruction memory contents are left as they are.
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing checksum byte is expected. The load succeeds
//     only if (sum of data bytes + checksum) mod 256 == 0; otherwise ERR.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   rx_data    incoming byte
//   rx_valid   rx_data valid
//   rx_ready   loader can accept a byte (decoded from state)
//   reload     level request to restart loading
//   rom_we     one-cycle instruction-memory write strobe
//   rom_addr   byte address of the write (multiple of 4)
//   rom_wdata  assembled instruction word
//   cpu_rstn   active-low reset to the CPU core
//   done       program loaded, CPU running
//   error      load rejected, CPU held in reset
module program_loader #(
    parameter int ROM_DEPTH  = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  reload,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [31:0]           rom_wdata,
    output logic                  cpu_rstn,
    output logic                  done,
    output logic                  error
);

    localparam int MAX_WORDS = ROM_DEPTH / 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd3;
`endif
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]  state;
    logic [7:0]  word_cnt;   // N from the header
    logic [7:0]  word_idx;   // index of the word being assembled
    logic [1:0]  byte_cnt;   // byte position within the current word
    logic [23:0] shift_reg;  // previous three bytes of the current word
    logic        accept;

    assign accept = rx_valid & rx_ready;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;
    // 8-bit wrap is the intended mod-256 arithmetic
    assign sum_next = sum + rx_data;
    assign rx_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_CHECK);
`else
    assign rx_ready = (state == S_IDLE) || (state == S_LOAD);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
            rom_we    <= 1'b0;
            rom_addr  <= '0;
            rom_wdata <= '0;
            cpu_rstn  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            rom_we <= 1'b0;
            // reload wins over any byte offered in the same cycle
            if (reload && state != S_IDLE) begin
                state    <= S_IDLE;
                word_idx <= '0;
                byte_cnt <= '0;
                cpu_rstn <= 1'b0;
                done     <= 1'b0;
                error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (rx_data == 8'd0 || int'(rx_data) > MAX_WORDS) begin
                                state <= S_ERR;
                                error <= 1'b1;
                            end else begin
                                state    <= S_LOAD;
                                word_cnt <= rx_data;
                                word_idx <= '0;
                                byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                                sum      <= '0;
`endif
                            end
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            shift_reg <= {shift_reg[15:0], rx_data};
                            byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                            sum       <= sum_next;
`endif
                            if (byte_cnt == 2'd3) begin
                                rom_we    <= 1'b1;
                                rom_wdata <= {shift_reg, rx_data};
                                rom_addr  <= ADDR_WIDTH'(word_idx) << 2;
                                word_idx  <= word_idx + 8'd1;
                                if (word_idx == word_cnt - 8'd1)
                                    state <= S_FLUSH;
                            end
                        end
                    end
                    // Final rom_we is high here; the CPU leaves reset only
                    // after this cycle so the last word is in memory first.
                    S_FLUSH: begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHECK;
`else
                        state    <= S_RUN;
                        cpu_rstn <= 1'b1;
                        done     <= 1'b1;
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        if (accept) begin
                            if (sum_next == 8'd0) begin
                                state    <= S_RUN;
                                cpu_rstn <= 1'b1;
                                done     <= 1'b1;
                            end else begin
                                state <= S_ERR;
                                error <= 1'b1;
                            end
                        end
                    end
`endif
                    S_RUN:   state <= S_RUN;
                    S_ERR:   state <= S_ERR;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
